// File: rtl/mbscore_bus_slave.sv
// mbscore_bus_slave: RAM-side responder on the MBScore shared memory bus.
// Owns DEPTH words in a BASE_ADDR window, inserts WAIT_STATES wait cycles,
// pulses ready (and err for misaligned accesses) for one cycle and drives
// read data onto the shared tristate bus only during that response cycle.
module mbscore_bus_slave #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           DEPTH       = 1024,
   parameter int unsigned           WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  ram_re,
   input  logic                  ram_we,
   inout  wire  [DATA_WIDTH-1:0] data,
   output logic                  ready,
   output logic                  err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;
   localparam int unsigned AX_W  = ADDR_WIDTH + 1;

   // Window bounds carry one extra bit so BASE_ADDR+4*DEPTH cannot overflow.
   localparam logic [AX_W-1:0]  WIN_LO   = {1'b0, BASE_ADDR};
   localparam logic [AX_W-1:0]  WIN_HI   = WIN_LO + AX_W'(4 * DEPTH);
   localparam logic [CNT_W-1:0] WS_LOAD  = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);
   localparam bit               HAS_WAIT = (WAIT_STATES != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                 state;
   state_t                 next_state;

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [ADDR_WIDTH-1:0]  offset_c;
   logic [IDX_W-1:0]       idx_c;
   logic                   hit_c;
   logic                   mis_c;
   logic                   req_c;

   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       lat_idx;
   logic                   lat_write;
   logic                   lat_mis;
   logic [DATA_WIDTH-1:0]  lat_wdata;

   logic [IDX_W-1:0]       cur_idx_c;
   logic                   cur_write_c;
   logic                   cur_mis_c;
   logic [DATA_WIDTH-1:0]  cur_wdata_c;

   logic                   ready_nxt;
   logic                   err_nxt;
   logic                   drive_nxt;
   logic                   commit_c;

   logic                   drive;
   logic [DATA_WIDTH-1:0]  rdata;

   // Address decode: window hit, word index and alignment of the live request.
   always_comb begin
      offset_c = addr - BASE_ADDR;
      idx_c    = IDX_W'(offset_c >> 2);
      hit_c    = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
      mis_c    = hit_c && (addr[1:0] != 2'b00);
      req_c    = hit_c && (ram_re || ram_we);
   end

   // Access parameters: live bus values while idle (zero-wait case), latched otherwise.
   always_comb begin
      cur_idx_c   = lat_idx;
      cur_write_c = lat_write;
      cur_mis_c   = lat_mis;
      cur_wdata_c = lat_wdata;
      if (state == S_IDLE) begin
         cur_idx_c   = idx_c;
         cur_write_c = ram_we;
         cur_mis_c   = mis_c;
         cur_wdata_c = data;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (req_c) begin
               next_state = HAS_WAIT ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               next_state = S_RESP;
            end
         end
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // FSM output decode: response flags and write commit for the edge entering RESP.
   always_comb begin
      ready_nxt = 1'b0;
      err_nxt   = 1'b0;
      drive_nxt = 1'b0;
      commit_c  = 1'b0;
      if (next_state == S_RESP) begin
         ready_nxt = 1'b1;
         err_nxt   = cur_mis_c;
         drive_nxt = !cur_write_c && !cur_mis_c;
         commit_c  = cur_write_c && !cur_mis_c;
      end
   end

   // Request latch and wait-state counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         lat_idx   <= '0;
         lat_write <= 1'b0;
         lat_mis   <= 1'b0;
         lat_wdata <= '0;
      end else if ((state == S_IDLE) && req_c) begin
         cnt       <= WS_LOAD;
         lat_idx   <= idx_c;
         lat_write <= ram_we;
         lat_mis   <= mis_c;
         lat_wdata <= ram_we ? data : '0;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
         cnt       <= cnt - CNT_W'(1);
      end
   end

   // Registered response outputs and read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready <= 1'b0;
         err   <= 1'b0;
         drive <= 1'b0;
         rdata <= '0;
      end else begin
         ready <= ready_nxt;
         err   <= err_nxt;
         drive <= drive_nxt;
         if (ready_nxt) begin
            rdata <= mem[cur_idx_c];
         end
      end
   end

   // Word array; a reset edge discards any pending write.
   always_ff @(posedge clk) begin
      if (commit_c && !rst) begin
         mem[cur_idx_c] <= cur_wdata_c;
      end
   end

   // Drive the shared bus only for a good read response and never against a writer.
   assign data = (drive && !ram_we) ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mbscore_bus_slave.sv
// Testbench: three slaves share one bus in disjoint windows with different
// wait-state counts; a scoreboard queue holds the expected response cycle,
// flags and bus value for every issued request.
`timescale 1ns/1ps
module tb_mbscore_bus_slave;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] addr = '0;
   logic          ram_re = 1'b0;
   logic          ram_we = 1'b0;
   logic          tb_oe = 1'b0;
   logic [DW-1:0] tb_wdata = '0;
   wire  [DW-1:0] data;
   logic          ready_a, ready_b, ready_c;
   logic          err_a, err_b, err_c;

   int unsigned   cyc = 0;
   bit            mon_en = 1'b0;
   int            vectors = 0;
   int            miscompares = 0;

   typedef struct {
      int          inst;
      logic        err;
      logic        drv;
      logic [31:0] dat;
      int unsigned cyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [31:0]   model_mem [int unsigned];
   logic [31:0]   pool[$];
   int            ws_tab [3] = '{0, 1, 3};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign data = tb_oe ? tb_wdata : {DW{1'bz}};
   for (genvar g = 0; g < DW; g++) begin : g_pu
      pullup (data[g]);
   end

   mbscore_bus_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(32'h0000_0000),
                       .DEPTH(16), .WAIT_STATES(0)) u_a (
      .clk(clk), .rst(rst), .addr(addr), .ram_re(ram_re), .ram_we(ram_we),
      .data(data), .ready(ready_a), .err(err_a));

   mbscore_bus_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(32'h0000_1000),
                       .DEPTH(1024), .WAIT_STATES(1)) u_b (
      .clk(clk), .rst(rst), .addr(addr), .ram_re(ram_re), .ram_we(ram_we),
      .data(data), .ready(ready_b), .err(err_b));

   mbscore_bus_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(32'h0000_4000),
                       .DEPTH(8), .WAIT_STATES(3)) u_c (
      .clk(clk), .rst(rst), .addr(addr), .ram_re(ram_re), .ram_we(ram_we),
      .data(data), .ready(ready_c), .err(err_c));

   function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endfunction

   // Which slave owns a byte address (-1 = nobody).
   function automatic int win_of(logic [31:0] a);
      if (a < 32'h40) return 0;
      if (a >= 32'h1000 && a < 32'h2000) return 1;
      if (a >= 32'h4000 && a < 32'h4020) return 2;
      return -1;
   endfunction

   // Issue one request for a single cycle and queue the expected response.
   task automatic access(input logic [31:0] a, input logic re, input logic we,
                         input logic [31:0] wd);
      int   w;
      exp_t e;
      w = win_of(a);
      @(negedge clk);
      addr = a; ram_re = re; ram_we = we; tb_oe = we; tb_wdata = wd;
      if (w >= 0 && (re || we)) begin
         e.inst = w;
         e.err  = (a[1:0] != 2'b00);
         e.drv  = !we && !e.err;
         e.dat  = e.drv ? model_mem[a] : 32'hFFFF_FFFF;
         e.cyc  = cyc + 1 + ws_tab[w];
         exp_q.push_back(e);
         if (we && !e.err) model_mem[a] = wd;
      end
      @(negedge clk);
      ram_re = 1'b0; ram_we = 1'b0; tb_oe = 1'b0; addr = $urandom;
      repeat (((w >= 0) ? ws_tab[w] : 0) + 2) @(negedge clk);
   endtask

   // Monitor: compares every cycle against the head of the scoreboard.
   initial begin : monitor
      exp_t        e;
      logic [2:0]  rdy, er, one;
      logic [31:0] bus_exp;
      forever begin
         @(posedge clk);
         #2;
         if (mon_en) begin
            rdy     = {ready_c, ready_b, ready_a};
            er      = {err_c, err_b, err_a};
            bus_exp = tb_oe ? tb_wdata : 32'hFFFF_FFFF;
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
               e   = exp_q.pop_front();
               one = 3'b001 << e.inst;
               chk("resp_ready", 64'(rdy), 64'(one));
               chk("resp_err", 64'(er), e.err ? 64'(one) : 64'(0));
               chk("resp_bus", 64'(data), e.drv ? 64'(e.dat) : 64'(bus_exp));
            end else begin
               chk("idle_ready", 64'(rdy), 64'(0));
               chk("idle_err", 64'(er), 64'(0));
               chk("idle_bus", 64'(data), 64'(bus_exp));
            end
         end
      end
   end

   initial begin : stim
      logic [31:0] a, wd;
      int unsigned k;
      int          r, op;
      logic [31:0] oow [6] = '{32'h0000_0FFC, 32'h0000_2000, 32'h0000_0040,
                               32'h0000_4020, 32'h0000_3FFC, 32'hFFFF_FFFC};

      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Initialise every word the bench will read back.
      for (int i = 0; i < 16; i++) pool.push_back(32'(i * 4));
      for (int i = 0; i < 8; i++)  pool.push_back(32'h4000 + 32'(i * 4));
      pool.push_back(32'h1000); pool.push_back(32'h1004);
      pool.push_back(32'h1020); pool.push_back(32'h1FFC);
      foreach (pool[i]) access(pool[i], 1'b0, 1'b1, $urandom & 32'h7FFF_FFFF);

      // Write / read back, misaligned write, simultaneous re+we.
      access(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF);
      access(32'h10, 1'b1, 1'b0, 32'h0);
      access(32'h12, 1'b0, 1'b1, 32'h1234_5678);
      access(32'h10, 1'b1, 1'b0, 32'h0);
      access(32'h20, 1'b1, 1'b1, 32'hA5A5_A5A5);
      access(32'h20, 1'b1, 1'b0, 32'h0);
      access(32'h1020, 1'b1, 1'b1, 32'h5A5A_5A5A);
      access(32'h1020, 1'b1, 1'b0, 32'h0);
      access(32'h1FFE, 1'b1, 1'b0, 32'h0);

      // Window boundaries.
      foreach (oow[i]) access(oow[i], 1'b1, 1'b0, 32'h0);
      access(32'h1FFC, 1'b1, 1'b0, 32'h0);
      access(32'h1000, 1'b1, 1'b0, 32'h0);
      access(32'h003C, 1'b1, 1'b0, 32'h0);
      access(32'h401C, 1'b1, 1'b0, 32'h0);

      // Reset two cycles into a 3-wait-state write: nothing completes or commits.
      @(negedge clk);
      addr = 32'h4010; ram_we = 1'b1; tb_oe = 1'b1; tb_wdata = 32'h55;
      @(negedge clk);
      ram_we = 1'b0; tb_oe = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      access(32'h4010, 1'b1, 1'b0, 32'h0);

      // Request present only during a reset edge is not accepted.
      @(negedge clk);
      addr = 32'h8; ram_re = 1'b1; rst = 1'b1;
      @(negedge clk);
      ram_re = 1'b0; rst = 1'b0;
      repeat (4) @(negedge clk);

      // Held read on the zero-wait slave: a response every second cycle.
      @(negedge clk);
      k = cyc;
      addr = 32'h0; ram_re = 1'b1;
      for (int j = 0; j < 4; j++)
         exp_q.push_back('{inst: 0, err: 1'b0, drv: 1'b1, dat: model_mem[32'h0],
                           cyc: k + 1 + 32'(2 * j)});
      repeat (7) @(posedge clk);
      @(negedge clk);
      ram_re = 1'b0;
      repeat (3) @(negedge clk);

      // Randomised mix of reads, writes, misaligned and out-of-window accesses.
      for (int n = 0; n < 150; n++) begin
         r  = $urandom_range(0, 9);
         op = $urandom_range(0, 2);
         a  = pool[$urandom_range(0, pool.size() - 1)];
         if (r == 7) a = a + 32'($urandom_range(1, 3));
         else if (r >= 8) a = oow[$urandom_range(0, 5)];
         wd = $urandom & 32'hFFFF_FFFE;
         access(a, op != 1, op != 0, wd);
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
